// File: rtl/dtm_uart_cmd_ctrl_pkg.sv
// Shared types and constants for the UART DTM command sequencer.
//   cmd_t        : command field of the header byte {cmd[2:0], addr[4:0]}
//   addr_t       : register address field of the header byte
//   ctrl_state_t : command sequencer FSM states
package dtm_uart_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_READ  = 3'd0,
    CMD_WRITE = 3'd1,
    CMD_RESET = 3'd2
  } cmd_t;

  typedef enum logic [4:0] {
    ADDR_IDCODE = 5'h01,
    ADDR_DMI    = 5'h11
  } addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ESC_SEEN,
    ST_RX_PAYLOAD,
    ST_DMI_REQ,
    ST_DMI_RESP,
    ST_TX_RESP
  } ctrl_state_t;

  localparam int PAYLOAD_BYTES = 6;
  localparam int RESP_BYTES    = 5;
  localparam int IDCODE_BYTES  = 4;

endpackage

// File: rtl/dtm_uart_tx_stuffer.sv
// ESC stuffer on the transmit path. A byte offered on the byte_* handshake is
// forwarded to the UART transmitter; a byte equal to ESC goes out twice and is
// only acknowledged upstream once the second copy has been taken.
//   clk, rst_n              : clock, asynchronous active-low reset
//   byte_valid/data/ready   : upstream byte handshake (data held until ready)
//   tx_valid/data/ready     : UART transmitter handshake
module dtm_uart_tx_stuffer #(
  parameter logic [7:0] ESC = 8'hB1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready
);

  // High while the second copy of an ESC byte is being offered.
  logic second_q;

  assign tx_valid   = byte_valid;
  assign tx_data    = byte_data;
  assign byte_ready = tx_ready & ((byte_data != ESC) | second_q);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_q <= 1'b0;
    end else if (byte_valid && tx_ready && (byte_data == ESC)) begin
      second_q <= ~second_q;
    end
  end

endmodule

// File: rtl/dtm_uart_cmd_ctrl.sv
// Command sequencer between the UART byte channel and the DMI port.
// Frames ESC-delimited commands, assembles LSB-first payloads into DMI
// requests, captures DMI responses and streams them back over UART TX.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   rx_valid/rx_data/rx_ready   : received byte handshake
//   tx_valid/tx_data/tx_ready   : transmit byte handshake
//   dmi_req_valid/req/req_ready : DMI request {addr[6:0],data[31:0],op[1:0]}
//   dmi_resp_valid/resp/ready   : DMI response {data[31:0],resp[1:0]}
//   dmi_rst_n                   : one-cycle active-low DMI soft reset pulse
//   err                         : sticky timeout / unknown header flag
module dtm_uart_cmd_ctrl
  import dtm_uart_cmd_ctrl_pkg::*;
#(
  parameter logic [7:0]  ESC     = 8'hB1,
  parameter logic [31:0] IDCODE  = 32'h1,
  parameter int          TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        dmi_req_valid,
  output logic [40:0] dmi_req,
  input  logic        dmi_req_ready,
  input  logic        dmi_resp_valid,
  input  logic [33:0] dmi_resp,
  output logic        dmi_resp_ready,
  output logic        dmi_rst_n,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  ctrl_state_t   state_q, state_d, hdr_next;
  logic          ready_en_q, esc_q, wr_q, tx_id_q, dmi_rst_n_q, err_q;
  logic [2:0]    cnt_q;
  logic [40:0]   req_q;
  logic [33:0]   resp_q;
  logic [TW-1:0] tmo_q;

  logic        rx_fire, rx_is_esc, hdr_fire, data_fire, payload_done;
  logic        hdr_write, hdr_reset, hdr_rd_dmi, hdr_rd_id, hdr_bad;
  logic        resp_fire, tmo_hit, tx_fire, tx_last, tx_byte_ready;
  logic [39:0] tx_word;
  logic [7:0]  tx_byte;

  // rx_ready stays low through reset and comes up on the first clock after it.
  assign rx_ready = ready_en_q & (state_q inside {ST_IDLE, ST_ESC_SEEN, ST_RX_PAYLOAD});
  assign rx_fire   = rx_valid & rx_ready;
  assign rx_is_esc = (rx_data == ESC);

  // A non-ESC byte after an unpaired ESC is a header, also mid-payload (abort).
  assign hdr_fire  = rx_fire & ~rx_is_esc &
                     ((state_q == ST_ESC_SEEN) | ((state_q == ST_RX_PAYLOAD) & esc_q));
  // Payload data is any plain byte, or the second ESC of an ESC,ESC pair.
  assign data_fire = rx_fire & (state_q == ST_RX_PAYLOAD) & (rx_is_esc == esc_q);
  assign payload_done = data_fire & (cnt_q == 3'(PAYLOAD_BYTES - 1));

  assign hdr_write  = (rx_data[7:5] == CMD_WRITE) & (rx_data[4:0] == ADDR_DMI);
  assign hdr_reset  = (rx_data[7:5] == CMD_RESET) & (rx_data[4:0] == ADDR_DMI);
  assign hdr_rd_dmi = (rx_data[7:5] == CMD_READ)  & (rx_data[4:0] == ADDR_DMI);
  assign hdr_rd_id  = (rx_data[7:5] == CMD_READ)  & (rx_data[4:0] == ADDR_IDCODE);
  assign hdr_bad    = ~(hdr_write | hdr_reset | hdr_rd_dmi | hdr_rd_id);

  assign resp_fire = (state_q == ST_DMI_RESP) & dmi_resp_valid;
  // A response in the final cycle takes priority over the timeout.
  assign tmo_hit   = (state_q == ST_DMI_RESP) & ~dmi_resp_valid & (tmo_q == TW'(TIMEOUT - 1));

  assign tx_word = tx_id_q ? {8'h00, IDCODE} : {6'b0, resp_q};
  assign tx_byte = tx_word[{cnt_q, 3'b000} +: 8];
  assign tx_fire = (state_q == ST_TX_RESP) & tx_byte_ready;
  assign tx_last = (cnt_q == (tx_id_q ? 3'(IDCODE_BYTES - 1) : 3'(RESP_BYTES - 1)));

  assign dmi_req_valid  = (state_q == ST_DMI_REQ);
  assign dmi_req        = req_q;
  assign dmi_resp_ready = (state_q == ST_DMI_RESP);
  assign dmi_rst_n      = dmi_rst_n_q;
  assign err            = err_q;

  dtm_uart_tx_stuffer #(.ESC(ESC)) u_tx_stuffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (state_q == ST_TX_RESP),
    .byte_data  (tx_byte),
    .byte_ready (tx_byte_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hdr_next = ST_IDLE;
    if (hdr_write | hdr_reset)      hdr_next = ST_RX_PAYLOAD;
    else if (hdr_rd_dmi | hdr_rd_id) hdr_next = ST_TX_RESP;

    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (rx_fire && rx_is_esc) state_d = ST_ESC_SEEN;
      ST_ESC_SEEN:   if (rx_fire) state_d = rx_is_esc ? ST_IDLE : hdr_next;
      ST_RX_PAYLOAD: begin
        if (hdr_fire)          state_d = hdr_next;
        else if (payload_done) state_d = wr_q ? ST_DMI_REQ : ST_IDLE;
      end
      ST_DMI_REQ:    if (dmi_req_ready) state_d = ST_DMI_RESP;
      ST_DMI_RESP:   if (resp_fire || tmo_hit) state_d = ST_IDLE;
      ST_TX_RESP:    if (tx_fire && tx_last) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // NOTE: the request/response holding registers are reset too; they are
  // small flops, and a READ right after reset must return zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q  <= 1'b0;
      esc_q       <= 1'b0;
      wr_q        <= 1'b0;
      tx_id_q     <= 1'b0;
      dmi_rst_n_q <= 1'b1;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      req_q       <= '0;
      resp_q      <= '0;
      tmo_q       <= '0;
    end else begin
      ready_en_q <= 1'b1;

      if (state_q == ST_RX_PAYLOAD) begin
        if (rx_fire) esc_q <= rx_is_esc & ~esc_q;
      end else begin
        esc_q <= 1'b0;
      end

      if (hdr_fire) begin
        cnt_q   <= '0;
        wr_q    <= hdr_write;
        tx_id_q <= hdr_rd_id;
        if (hdr_bad) err_q <= 1'b1;
      end else if (data_fire) begin
        cnt_q <= cnt_q + 3'd1;
        // Bytes land LSB-first; only bit 0 of the sixth byte is kept.
        if (wr_q) begin
          if (cnt_q == 3'd5) req_q[40] <= rx_data[0];
          else               req_q[{cnt_q, 3'b000} +: 8] <= rx_data;
        end
      end else if (tx_fire) begin
        cnt_q <= tx_last ? 3'd0 : cnt_q + 3'd1;
      end

      dmi_rst_n_q <= ~(payload_done & ~wr_q);
      if (payload_done && !wr_q) begin
        resp_q <= '0;
        err_q  <= 1'b0;
      end

      if (resp_fire) resp_q <= dmi_resp;
      if (tmo_hit)   err_q  <= 1'b1;

      tmo_q <= (state_q == ST_DMI_RESP) ? tmo_q + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_dtm_uart_cmd_ctrl.sv
// Scoreboard bench for dtm_uart_cmd_ctrl: stimulus pushes expected TX bytes and
// DMI requests into queues; a monitor pops and compares on each handshake.
module tb_dtm_uart_cmd_ctrl;

  localparam logic [7:0] ESC     = 8'hB1;
  localparam int         TIMEOUT = 64;
  // Header bytes {cmd,addr}: READ=0, WRITE=1, RESET=2; DMI=0x11, IDCODE=0x01.
  localparam logic [7:0] H_RD_DMI  = 8'h11;
  localparam logic [7:0] H_WR_DMI  = 8'h31;
  localparam logic [7:0] H_RST_DMI = 8'h51;
  localparam logic [7:0] H_RD_ID   = 8'h01;
  localparam logic [7:0] H_BAD     = 8'hE0;

  logic        clk, rst_n;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0]  rx_data, tx_data;
  logic        dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_ready;
  logic [40:0] dmi_req;
  logic [33:0] dmi_resp;
  logic        dmi_rst_n, err;

  logic [7:0]  tx_exp[$];
  logic [40:0] req_exp[$];
  int          n_pass = 0, n_total = 0;
  int          req_cnt = 0, rst_low_cnt = 0;
  logic        tx_toggle = 1'b0;

  dtm_uart_cmd_ctrl #(.ESC(ESC), .IDCODE(32'h1), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .dmi_req_valid(dmi_req_valid), .dmi_req(dmi_req), .dmi_req_ready(dmi_req_ready),
    .dmi_resp_valid(dmi_resp_valid), .dmi_resp(dmi_resp), .dmi_resp_ready(dmi_resp_ready),
    .dmi_rst_n(dmi_rst_n), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Only this process drives tx_ready: toggles every cycle when requested.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tx_toggle) tx_ready = ~tx_ready;
      else           tx_ready = 1'b1;
    end
  end

  // Monitor: compares each handshake against the queues, checks hold stability.
  initial begin : monitor
    logic        tx_hold, req_hold, have;
    logic [7:0]  tx_hold_d;
    logic [40:0] req_hold_d;
    tx_hold = 1'b0; req_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_hold = 1'b0; req_hold = 1'b0;
      end else begin
        if (tx_valid) begin
          if (tx_hold) check("tx_stable", tx_data, tx_hold_d);
          if (tx_ready) begin
            have = (tx_exp.size() != 0);
            check("tx_expected_pending", have, 1);
            if (have) check("tx_byte", tx_data, tx_exp.pop_front());
            tx_hold = 1'b0;
          end else begin
            tx_hold = 1'b1; tx_hold_d = tx_data;
          end
        end else tx_hold = 1'b0;

        if (dmi_req_valid) begin
          if (req_hold) check("req_stable", dmi_req, req_hold_d);
          if (dmi_req_ready) begin
            req_cnt++;
            have = (req_exp.size() != 0);
            check("req_expected_pending", have, 1);
            if (have) check("dmi_req", dmi_req, req_exp.pop_front());
            req_hold = 1'b0;
          end else begin
            req_hold = 1'b1; req_hold_d = dmi_req;
          end
        end else req_hold = 1'b0;

        if (!dmi_rst_n) rst_low_cnt++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1; rx_data = b;
    do begin @(negedge clk); n++; end while (!rx_ready && n < 500);
    if (!rx_ready) check("rx_accept_timeout", rx_ready, 1);
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send_data(input logic [7:0] b);
    send_byte(b);
    if (b == ESC) send_byte(ESC);
  endtask

  task automatic send_hdr(input logic [7:0] h);
    send_byte(ESC);
    send_byte(h);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((tx_exp.size() != 0 || req_exp.size() != 0) && n < 2000) begin
      @(posedge clk); n++;
    end
    #1 check(name, tx_exp.size() + req_exp.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic dmi_respond(input logic [33:0] v);
    int n = 0;
    while (!dmi_resp_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (!dmi_resp_ready) check("resp_ready_timeout", dmi_resp_ready, 1);
    dmi_resp_valid = 1'b1; dmi_resp = v;
    @(posedge clk); #1;
    dmi_resp_valid = 1'b0; dmi_resp = '0;
  endtask

  task automatic push_tx5(input logic [7:0] b0, b1, b2, b3, b4);
    tx_exp.push_back(b0); tx_exp.push_back(b1); tx_exp.push_back(b2);
    tx_exp.push_back(b3); tx_exp.push_back(b4);
  endtask

  initial begin
    int r0, q0, n;
    rst_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    dmi_req_ready = 1'b1; dmi_resp_valid = 1'b0; dmi_resp = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_req_valid", dmi_req_valid, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_resp_ready", dmi_resp_ready, 0);
    check("rst_dmi_rst_n", dmi_rst_n, 1);
    check("rst_err", err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rx_ready_after_rst", rx_ready, 1);

    // 1: WRITE -> one request; payload FC400000_0001 keeps bits[40:0].
    req_exp.push_back(41'h040_0000_0001);
    send_hdr(H_WR_DMI);
    send_data(8'h01); send_data(8'h00); send_data(8'h00);
    send_data(8'h00); send_data(8'h40); send_data(8'hFC);
    dmi_respond(34'h4);
    wait_drain("t1_drain");
    check("t1_req_cnt", req_cnt, 1);
    check("t1_err", err, 0);

    // 2: READ DMI twice -> identical response bytes.
    push_tx5(8'h04, 8'h00, 8'h00, 8'h00, 8'h00);
    send_hdr(H_RD_DMI);
    wait_drain("t2_drain_a");
    push_tx5(8'h04, 8'h00, 8'h00, 8'h00, 8'h00);
    send_hdr(H_RD_DMI);
    wait_drain("t2_drain_b");

    // 3: RESET command -> single-cycle dmi_rst_n pulse, response cleared.
    r0 = rst_low_cnt; q0 = req_cnt;
    send_hdr(H_RST_DMI);
    send_data(8'hFE); send_data(8'hFF); send_data(8'hFF);
    send_data(8'hFF); send_data(8'h43); send_data(8'hFC);
    repeat (4) @(posedge clk); #1;
    check("t3_rst_pulse_cycles", rst_low_cnt - r0, 1);
    check("t3_no_req", req_cnt - q0, 0);
    check("t3_err", err, 0);
    push_tx5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_hdr(H_RD_DMI);
    wait_drain("t3_drain");

    // 4a: escaped ESC as payload byte 1 -> bits[15:8] = B1.
    req_exp.push_back(41'h000_0000_B100);
    send_hdr(H_WR_DMI);
    send_data(8'h00); send_data(ESC); send_data(8'h00);
    send_data(8'h00); send_data(8'h00); send_data(8'h00);
    dmi_respond(34'h0);
    wait_drain("t4_drain_a");
    // 4b: WRITE aborted after 3 bytes by READ IDCODE.
    q0 = req_cnt;
    tx_exp.push_back(8'h01); tx_exp.push_back(8'h00);
    tx_exp.push_back(8'h00); tx_exp.push_back(8'h00);
    send_hdr(H_WR_DMI);
    send_data(8'h11); send_data(8'h22); send_data(8'h33);
    send_hdr(H_RD_ID);
    wait_drain("t4_drain_b");
    check("t4_abort_no_req", req_cnt - q0, 0);
    // 4c: unknown header sets err; RESET command clears it.
    send_hdr(H_BAD);
    @(posedge clk); #1;
    check("t4_bad_hdr_err", err, 1);
    send_hdr(H_RST_DMI);
    repeat (6) send_data(8'h00);
    @(posedge clk); #1;
    check("t4_err_cleared", err, 0);

    // 5: request held under back-pressure, then DMI never responds.
    dmi_req_ready = 1'b0;
    req_exp.push_back(41'h000_1234_5678);
    send_hdr(H_WR_DMI);
    send_data(8'h78); send_data(8'h56); send_data(8'h34);
    send_data(8'h12); send_data(8'h00); send_data(8'h00);
    repeat (10) @(posedge clk);
    #1 dmi_req_ready = 1'b1;
    n = 0;
    while (!dmi_resp_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("t5_resp_wait_entered", dmi_resp_ready, 1);
    repeat (TIMEOUT - 3) @(posedge clk);
    #1 check("t5_err_before_timeout", err, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_err_at_timeout", err, 1);
    check("t5_idle_rx_ready", rx_ready, 1);
    check("t5_idle_resp_ready", dmi_resp_ready, 0);
    tx_exp.push_back(8'h01); tx_exp.push_back(8'h00);
    tx_exp.push_back(8'h00); tx_exp.push_back(8'h00);
    send_hdr(H_RD_ID);
    wait_drain("t5_drain");

    // 6: response byte 0 = B1 is stuffed; tx_ready toggling loses nothing.
    req_exp.push_back(41'h0);
    send_hdr(H_WR_DMI);
    repeat (6) send_data(8'h00);
    dmi_respond(34'h0B1);
    tx_toggle = 1'b1;
    tx_exp.push_back(ESC);
    push_tx5(ESC, 8'h00, 8'h00, 8'h00, 8'h00);
    send_hdr(H_RD_DMI);
    wait_drain("t6_drain_toggle");
    tx_toggle = 1'b0;
    repeat (2) @(posedge clk); #1;
    // Reset in the middle of a response stream.
    tx_exp.push_back(ESC);
    push_tx5(ESC, 8'h00, 8'h00, 8'h00, 8'h00);
    send_hdr(H_RD_DMI);
    n = 0;
    while (tx_exp.size() > 3 && n < 200) begin @(posedge clk); #1; n++; end
    rst_n = 1'b0;
    #1;
    check("t6_tx_valid_in_rst", tx_valid, 0);
    check("t6_rx_ready_in_rst", rx_ready, 0);
    check("t6_err_in_rst", err, 0);
    tx_exp.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push_tx5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_hdr(H_RD_DMI);
    wait_drain("t6_drain_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
